call_stack: RTL and testbench

- Hardware return-address stack that sits beside the control unit.
- The control unit pushes {PC, ALU flags} on `call m` and pops them on `ret`.
- It holds DEPTH entries in registers and exposes the top entry combinationally, so the control unit can restore PC and flags in the same cycle as the pop.
- It detects overflow and underflow, and locks into a fault state until explicitly cleared.

---
 rtl/call_stack_if.sv | 44 ++++
 rtl/call_stack.sv | 120 ++++++++++++
 tb/tb_call_stack.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/call_stack_if.sv
// Bundle between the control unit and the return-address stack.
// With CALL_STACK_WATERMARK_EN defined, the bundle also carries the high-water mark.
interface call_stack_if #(
    parameter int PC_WIDTH    = 8,
    parameter int FLAGS_WIDTH = 4,
    parameter int SP_WIDTH    = 3
);
    logic                   push;
    logic                   pop;
    logic                   clear;
    logic [PC_WIDTH-1:0]    pc;
    logic [FLAGS_WIDTH-1:0] flags;
    logic [PC_WIDTH-1:0]    top_pc;
    logic [FLAGS_WIDTH-1:0] top_flags;
    logic [SP_WIDTH-1:0]    sp;
    logic                   empty;
    logic                   full;
    logic                   overflow;
    logic                   underflow;
    logic                   fault;
`ifdef CALL_STACK_WATERMARK_EN
    logic [SP_WIDTH-1:0]    max_depth;
`endif

    modport master (
        output push, pop, clear, pc, flags,
        input  top_pc, top_flags, sp, empty, full, overflow, underflow,
`ifdef CALL_STACK_WATERMARK_EN
        input  fault, max_depth
`else
        input  fault
`endif
    );

    modport slave (
        input  push, pop, clear, pc, flags,
        output top_pc, top_flags, sp, empty, full, overflow, underflow,
`ifdef CALL_STACK_WATERMARK_EN
        output fault, max_depth
`else
        output fault
`endif
    );
endinterface

// File: rtl/call_stack.sv
// Register-based return-address stack of {PC, flags} with sticky overflow/underflow fault.
// Optional high-water mark output enabled by defining CALL_STACK_WATERMARK_EN.
module call_stack #(
    parameter int PC_WIDTH    = 8,
    parameter int FLAGS_WIDTH = 4,
    parameter int DEPTH       = 5,
    parameter int SP_WIDTH    = 3
) (
    input logic         clk,
    input logic         rst_n,
    call_stack_if.slave bus
);
    localparam int ENTRY_WIDTH = PC_WIDTH + FLAGS_WIDTH;
    localparam logic [SP_WIDTH-1:0] SP_DEPTH = SP_WIDTH'(DEPTH);
    localparam logic [SP_WIDTH-1:0] SP_ONE   = SP_WIDTH'(1);

    typedef enum logic {RUN, FAULT} state_t;

    state_t                 state, state_next;
    logic [SP_WIDTH-1:0]    sp, sp_next;
    logic                   overflow, overflow_next;
    logic                   underflow, underflow_next;
    logic                   wr_en;
    logic [SP_WIDTH-1:0]    wr_idx;
    logic [SP_WIDTH-1:0]    top_idx;
    logic [ENTRY_WIDTH-1:0] top_entry;
    logic [ENTRY_WIDTH-1:0] entries [DEPTH];

    logic empty, full;
    assign empty   = (sp == '0);
    assign full    = (sp == SP_DEPTH);
    assign top_idx = sp - SP_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            state     <= state_next;
            sp        <= sp_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
            if (wr_en) begin
                entries[wr_idx] <= {bus.pc, bus.flags};
            end
        end
    end

    // Simultaneous push+pop replaces the top in place; on an empty stack it degrades to a push.
    always_comb begin
        state_next     = state;
        sp_next        = sp;
        overflow_next  = overflow;
        underflow_next = underflow;
        wr_en          = 1'b0;
        wr_idx         = sp;
        if (bus.clear) begin
            state_next     = RUN;
            sp_next        = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else if (state == RUN) begin
            if (bus.push && bus.pop) begin
                wr_en = 1'b1;
                if (empty) begin
                    sp_next = SP_ONE;
                end else begin
                    wr_idx = top_idx;
                end
            end else if (bus.push) begin
                if (full) begin
                    overflow_next = 1'b1;
                    state_next    = FAULT;
                end else begin
                    wr_en   = 1'b1;
                    sp_next = sp + SP_ONE;
                end
            end else if (bus.pop) begin
                if (empty) begin
                    underflow_next = 1'b1;
                    state_next     = FAULT;
                end else begin
                    sp_next = sp - SP_ONE;
                end
            end
        end
    end

    // The index is only used when sp is non-zero, so it never runs off the array.
    assign top_entry     = empty ? '0 : entries[top_idx];
    assign bus.top_pc    = top_entry[ENTRY_WIDTH-1:FLAGS_WIDTH];
    assign bus.top_flags = top_entry[FLAGS_WIDTH-1:0];
    assign bus.sp        = sp;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
    assign bus.fault     = (state == FAULT);

`ifdef CALL_STACK_WATERMARK_EN
    logic [SP_WIDTH-1:0] max_depth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_depth <= '0;
        end else if (bus.clear) begin
            max_depth <= '0;
        end else if (sp_next > max_depth) begin
            max_depth <= sp_next;
        end
    end

    assign bus.max_depth = max_depth;
`endif
endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: queue-based reference model compared every cycle,
// plus directed literal expectations. Watermark checks compile in with CALL_STACK_WATERMARK_EN.
module tb_call_stack;
    localparam int PC_WIDTH    = 8;
    localparam int FLAGS_WIDTH = 4;
    localparam int DEPTH       = 5;
    localparam int SP_WIDTH    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    call_stack_if #(.PC_WIDTH(PC_WIDTH), .FLAGS_WIDTH(FLAGS_WIDTH), .SP_WIDTH(SP_WIDTH)) bus();

    call_stack #(
        .PC_WIDTH(PC_WIDTH), .FLAGS_WIDTH(FLAGS_WIDTH), .DEPTH(DEPTH), .SP_WIDTH(SP_WIDTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Reference model: a queue whose back is the top of stack.
    logic [11:0] stackModel[$];
    bit          ovfModel;
    bit          unfModel;
    bit          faultModel;
    int          maxModel;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stackModel.delete();
            ovfModel   = 0;
            unfModel   = 0;
            faultModel = 0;
            maxModel   = 0;
        end else begin
            if (bus.clear) begin
                stackModel.delete();
                ovfModel   = 0;
                unfModel   = 0;
                faultModel = 0;
                maxModel   = 0;
            end else if (!faultModel) begin
                if (bus.push && bus.pop) begin
                    if (stackModel.size() == 0) stackModel.push_back({bus.pc, bus.flags});
                    else stackModel[stackModel.size()-1] = {bus.pc, bus.flags};
                end else if (bus.push) begin
                    if (stackModel.size() == DEPTH) begin
                        ovfModel   = 1;
                        faultModel = 1;
                    end else begin
                        stackModel.push_back({bus.pc, bus.flags});
                    end
                end else if (bus.pop) begin
                    if (stackModel.size() == 0) begin
                        unfModel   = 1;
                        faultModel = 1;
                    end else begin
                        void'(stackModel.pop_back());
                    end
                end
            end
            if (stackModel.size() > maxModel) maxModel = stackModel.size();
        end
    end

    function automatic logic [11:0] modelTop();
        logic [11:0] e;
        e = '0;
        if (stackModel.size() != 0) e = stackModel[stackModel.size()-1];
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [11:0] t;
        t = modelTop();
        checkOutput("model_top_pc",    32'(bus.top_pc),    32'(t[11:4]));
        checkOutput("model_top_flags", 32'(bus.top_flags), 32'(t[3:0]));
        checkOutput("model_sp",        32'(bus.sp),        32'(stackModel.size()));
        checkOutput("model_empty",     32'(bus.empty),     32'(stackModel.size() == 0));
        checkOutput("model_full",      32'(bus.full),      32'(stackModel.size() == DEPTH));
        checkOutput("model_overflow",  32'(bus.overflow),  32'(ovfModel));
        checkOutput("model_underflow", 32'(bus.underflow), 32'(unfModel));
        checkOutput("model_fault",     32'(bus.fault),     32'(faultModel));
`ifdef CALL_STACK_WATERMARK_EN
        checkOutput("model_max_depth", 32'(bus.max_depth), 32'(maxModel));
`endif
    end

    // One cycle of requests; inputs are driven 1 time unit after the edge and idled afterwards.
    task automatic applyStimulus(input bit push, input bit pop, input bit clear,
                                 input logic [7:0] pc, input logic [3:0] flags);
        bus.push  = push;
        bus.pop   = pop;
        bus.clear = clear;
        bus.pc    = pc;
        bus.flags = flags;
        @(posedge clk);
        #1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        bus.clear = 1'b0;
        bus.pc    = '0;
        bus.flags = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("reset_sp",    32'(bus.sp),    32'd0);
        checkOutput("reset_empty", 32'(bus.empty), 32'd1);
        checkOutput("reset_fault", 32'(bus.fault), 32'd0);
        checkOutput("reset_top",   32'(bus.top_pc), 32'd0);

        applyStimulus(1, 0, 0, 8'h12, 4'h5);
        checkOutput("push1_top_pc",    32'(bus.top_pc),    32'h12);
        checkOutput("push1_top_flags", 32'(bus.top_flags), 32'h5);
        checkOutput("push1_sp",        32'(bus.sp),        32'd1);
        checkOutput("push1_empty",     32'(bus.empty),     32'd0);
        applyStimulus(0, 0, 1, 8'h00, 4'h0);

        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'(8'h10 + i), 4'(i));
        checkOutput("fill_full", 32'(bus.full), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("pop_order_top", 32'(bus.top_pc), 32'(8'h14 - i));
            applyStimulus(0, 1, 0, 8'h00, 4'h0);
        end
        checkOutput("drained_sp",    32'(bus.sp),     32'd0);
        checkOutput("drained_top",   32'(bus.top_pc), 32'd0);
        checkOutput("drained_empty", 32'(bus.empty),  32'd1);

        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 8'(8'h10 + i), 4'(i));
        applyStimulus(1, 0, 0, 8'h99, 4'hF);
        checkOutput("ovf_flag",  32'(bus.overflow), 32'd1);
        checkOutput("ovf_fault", 32'(bus.fault),    32'd1);
        checkOutput("ovf_sp",    32'(bus.sp),       32'd5);
        checkOutput("ovf_top",   32'(bus.top_pc),   32'h14);
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        checkOutput("fault_pop_ignored", 32'(bus.sp), 32'd5);
        applyStimulus(0, 0, 1, 8'h00, 4'h0);
        checkOutput("clear_sp",    32'(bus.sp),       32'd0);
        checkOutput("clear_fault", 32'(bus.fault),    32'd0);
        checkOutput("clear_ovf",   32'(bus.overflow), 32'd0);

        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        checkOutput("unf_flag",  32'(bus.underflow), 32'd1);
        checkOutput("unf_fault", 32'(bus.fault),     32'd1);
        checkOutput("unf_sp",    32'(bus.sp),        32'd0);
        applyStimulus(1, 0, 0, 8'h44, 4'h1);
        checkOutput("fault_push_ignored", 32'(bus.sp), 32'd0);
        applyStimulus(0, 0, 1, 8'h00, 4'h0);
        checkOutput("clear_unf", 32'(bus.underflow), 32'd0);

        applyStimulus(1, 0, 0, 8'h20, 4'h2);
        applyStimulus(1, 0, 0, 8'h21, 4'h3);
        checkOutput("pre_swap_top", 32'(bus.top_pc), 32'h21);
        applyStimulus(1, 1, 0, 8'h7F, 4'hA);
        checkOutput("swap_sp",        32'(bus.sp),        32'd2);
        checkOutput("swap_top_pc",    32'(bus.top_pc),    32'h7F);
        checkOutput("swap_top_flags", 32'(bus.top_flags), 32'hA);
        applyStimulus(0, 0, 1, 8'h00, 4'h0);
        applyStimulus(1, 1, 0, 8'h33, 4'h4);
        checkOutput("swap_empty_sp",  32'(bus.sp),        32'd1);
        checkOutput("swap_empty_top", 32'(bus.top_pc),    32'h33);
        checkOutput("swap_empty_unf", 32'(bus.underflow), 32'd0);

        applyStimulus(0, 0, 1, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'(8'h30 + i), 4'(i));
        bus.push = 1'b1;
        bus.pc   = 8'h55;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_sp",    32'(bus.sp),     32'd0);
        checkOutput("async_rst_empty", 32'(bus.empty),  32'd1);
        checkOutput("async_rst_top",   32'(bus.top_pc), 32'd0);
        bus.push = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        applyStimulus(1, 0, 0, 8'h40, 4'h0);
        applyStimulus(1, 0, 0, 8'h41, 4'h1);
        applyStimulus(1, 0, 0, 8'h42, 4'h2);
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(0, 1, 0, 8'h00, 4'h0);
        applyStimulus(1, 0, 0, 8'h43, 4'h3);
        checkOutput("wm_seq_sp",  32'(bus.sp),     32'd2);
        checkOutput("wm_seq_top", 32'(bus.top_pc), 32'h43);
`ifdef CALL_STACK_WATERMARK_EN
        checkOutput("wm_max_depth", 32'(bus.max_depth), 32'd3);
        applyStimulus(0, 0, 1, 8'h00, 4'h0);
        checkOutput("wm_clear", 32'(bus.max_depth), 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
